alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, handshaked successor to the single-cycle scalar/FP-single ALU. It keeps the existing command encoding and adds SUB and an iterative multi-cycle MUL. Every result is registered behind valid/ready, with a transaction tag and per-result IEEE exception flags. It sits between the issue stage and writeback, so writeback can stall without losing results.

Parameters:
XLEN, 32, integer datapath width for ADD/SUB/MOV/MUL; must be >= 32. FP ops use bits [31:0].
CMD_W, 8, width of alu_cmd_i.
TAG_W, 4, width of the pass-through transaction tag.

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
in_valid_i  in  1  request valid
in_ready_o  out  1  request accepted when in_valid_i && in_ready_o
alu_cmd_i  in  CMD_W  operation code
rs1_data_i  in  XLEN  operand 1
rs2_data_i  in  XLEN  operand 2
tag_i  in  TAG_W  opaque id, returned unchanged
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
rd_data_o  out  XLEN  result
zero_o  out  1  rd_data_o == 0
tag_o  out  TAG_W  tag of the current result
fflags_o  out  5  {NV,DZ,OF,UF,NX} for the current result
illegal_o  out  1  current result came from an unknown command
busy_o  out  1  MUL iteration in progress

Behaviour:
- Reset (async, rst_ni=0): state=IDLE. out_valid_o=0, rd_data_o=0, tag_o=0, fflags_o=0, illegal_o=0, busy_o=0. zero_o is combinational from rd_data_o, so it reads 1.
- FSM states: IDLE, MUL_RUN, OUT_HOLD.
  - IDLE: accept a request, then go to OUT_HOLD (single-cycle op) or MUL_RUN (MUL).
  - MUL_RUN: after XLEN iterations, go to OUT_HOLD.
  - OUT_HOLD: on out_ready_i, go to IDLE, or accept the next request in the same cycle.
- in_ready_o = (state != MUL_RUN) && (!out_valid_o || out_ready_i). This gives a full-throughput 1-deep pipeline for single-cycle ops.
- Latency:
  - Single-cycle ops: out_valid_o is asserted the cycle after acceptance.
  - MUL: XLEN+1 cycles.
- Output stability: while out_valid_o && !out_ready_i, rd_data_o, tag_o, fflags_o and illegal_o hold stable.
- Commands (decimal):
  - 1 ADD: result = rs1+rs2, mod 2^XLEN.
  - 4 SUB: result = rs1-rs2, mod 2^XLEN.
  - 2, 3 MOV: result = rs1.
  - 90 MUL: low XLEN bits of rs1*rs2. Shift-add, one bit per cycle, busy_o=1 in MUL_RUN. Operands are latched at acceptance.
  - 74 FSGNJ: {rs2[31], rs1[30:0]}.
  - 75 FSGNJN: {~rs2[31], rs1[30:0]}.
  - 76 FSGNJX: {rs1[31]^rs2[31], rs1[30:0]}.
  - 85 FCLASS: one-hot 10-bit class of rs1[31:0], standard RISC-V bit order. Bits: 0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.
  - 79 FCVT.W.S: float to signed int32, round toward zero.
  - 80 FCVT.WU.S: float to unsigned int32, round toward zero.
  - 86 FCVT.S.W: signed int32 to float, round to nearest even.
  - 87 FCVT.S.WU: unsigned int32 to float, round to nearest even.
  - Any other code: result 0, illegal_o=1, fflags 0, latency 1.
- Float-to-int saturation, all with NV=1:
  - NaN: 0x7FFFFFFF for W, 0xFFFFFFFF for WU.
  - +inf or positive overflow: max value.
  - -inf or negative overflow: 0x80000000 for W, 0 for WU.
  - Negative input to WU that truncates to nonzero: 0. Negative input whose truncated value is 0: result 0, NV=0.
  - NX=1 when nonzero fraction bits are discarded and NV=0.
- Int-to-float: NX=1 when rounding occurs. OF, UF and DZ are always 0.
- Width rules:
  - FP results are placed in [31:0].
  - FCVT.W(U).S results are sign-extended to XLEN (RV64 convention).
  - All other FP results are zero-extended to XLEN.
- fflags_o is per-result, not sticky.
- A MUL in progress cannot be aborted except by reset. Reset mid-MUL discards it and no result is produced.

Decomposition:
- Package alu_seq_pkg:
  - command localparams: CMD_ADD=1, CMD_MOV0=2, CMD_MOV1=3, CMD_SUB=4, CMD_FSGNJ=74, CMD_FSGNJN=75, CMD_FSGNJX=76, CMD_FCVT_W_S=79, CMD_FCVT_WU_S=80, CMD_FCLASS=85, CMD_FCVT_S_W=86, CMD_FCVT_S_WU=87, CMD_MUL=90.
  - fflag bit indices (NV=4 … NX=0).
  - FCLASS bit indices.
  - state enum.
- Sub-module fp_cvt_unit: combinational converter for all four FCVT modes. Inputs a[31:0], signed, dir. Outputs result[31:0], nv, nx.
- Sign-injection and FCLASS stay inline.

Test Plan:
- Reset, then ADD 5+7 with tag 3 and out_ready=1. Expect out_valid one cycle later, rd=12, tag_o=3, zero_o=0. Back-to-back ADDs sustain 1 result per cycle.
- SUB 7-7 with out_ready held 0 for 4 cycles. Expect rd=0, zero_o=1, stable, in_ready=0 until out_ready=1.
- MUL 3 × 0xFFFFFFFF at XLEN=32. Expect busy_o=1 for 32 cycles, out_valid at cycle 33, rd=0xFFFFFFFD. Deassert rst_ni mid-MUL: no result, all outputs at reset values.
- FCVT.W.S:
  - 0x40490FDB (3.14159): rd=3, NX=1.
  - 0x7FC00000 (NaN): rd=0x7FFFFFFF, NV=1.
  - 0xCF800000 (-2^32): rd=0x80000000, NV=1.
  - FCVT.WU.S 0xBF800000 (-1.0): rd=0, NV=1.
- FCVT.S.W 16777217 gives 0x4B800000 with NX=1. FCVT.S.WU 0xFFFFFFFF gives 0x4F800000 with NX=1.
- FSGNJN 0x3F800000, 0x3F800000 gives 0xBF800000. FCLASS 0x80000000 gives 0x008. Command 200 gives rd=0, illegal_o=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the handshaked sequential ALU: command codes,
// exception-flag and FCLASS bit positions, and the control FSM state type.
package alu_seq_pkg;

    localparam int unsigned CMD_ADD       = 32'd1;
    localparam int unsigned CMD_MOV0      = 32'd2;
    localparam int unsigned CMD_MOV1      = 32'd3;
    localparam int unsigned CMD_SUB       = 32'd4;
    localparam int unsigned CMD_FSGNJ     = 32'd74;
    localparam int unsigned CMD_FSGNJN    = 32'd75;
    localparam int unsigned CMD_FSGNJX    = 32'd76;
    localparam int unsigned CMD_FCVT_W_S  = 32'd79;
    localparam int unsigned CMD_FCVT_WU_S = 32'd80;
    localparam int unsigned CMD_FCLASS    = 32'd85;
    localparam int unsigned CMD_FCVT_S_W  = 32'd86;
    localparam int unsigned CMD_FCVT_S_WU = 32'd87;
    localparam int unsigned CMD_MUL       = 32'd90;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam int FCLASS_NEG_INF  = 0;
    localparam int FCLASS_NEG_NORM = 1;
    localparam int FCLASS_NEG_SUB  = 2;
    localparam int FCLASS_NEG_ZERO = 3;
    localparam int FCLASS_POS_ZERO = 4;
    localparam int FCLASS_POS_SUB  = 5;
    localparam int FCLASS_POS_NORM = 6;
    localparam int FCLASS_POS_INF  = 7;
    localparam int FCLASS_SNAN     = 8;
    localparam int FCLASS_QNAN     = 9;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_RUN  = 2'd1,
        ST_OUT_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_fp_cvt.sv
// Combinational single-precision <-> int32 converter. i_dir=0 converts float
// to int (truncating, saturating); i_dir=1 converts int to float (RNE).
module fp_cvt_unit
    import alu_seq_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic        i_signed,
    input  logic        i_dir,
    output logic [31:0] o_result,
    output logic        o_nv,
    output logic        o_nx
);

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_man;
    logic [55:0] w_wide;
    logic [32:0] w_int;
    logic [31:0] w_sat_pos;
    logic [31:0] w_sat_neg;
    logic [31:0] w_f2i_res;
    logic        w_f2i_nv;
    logic        w_f2i_nx;

    logic        w_i2f_sign;
    logic [31:0] w_mag;
    logic [4:0]  w_msb;
    logic [31:0] w_norm;
    logic [23:0] w_sig;
    logic        w_guard;
    logic        w_sticky;
    logic        w_rup;
    logic [24:0] w_sig_rnd;
    logic [7:0]  w_fexp;
    logic [31:0] w_i2f_res;
    logic        w_i2f_nx;

    assign w_sign    = i_a[31];
    assign w_exp     = i_a[30:23];
    assign w_man     = i_a[22:0];
    assign w_sat_pos = i_signed ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
    assign w_sat_neg = i_signed ? 32'h8000_0000 : 32'h0000_0000;

    // Float to int: magnitude is placed as 33.23 fixed point, then range-checked.
    always_comb begin
        w_wide    = 56'd0;
        w_int     = 33'd0;
        w_f2i_res = 32'd0;
        w_f2i_nv  = 1'b0;
        w_f2i_nx  = 1'b0;
        if (w_exp == 8'hFF) begin
            w_f2i_nv  = 1'b1;
            w_f2i_res = (w_sign && (w_man == 23'd0)) ? w_sat_neg : w_sat_pos;
        end else if (w_exp < 8'd127) begin
            w_f2i_res = 32'd0;
            w_f2i_nx  = (w_exp != 8'd0) || (w_man != 23'd0);
        end else if (w_exp > 8'd158) begin
            w_f2i_nv  = 1'b1;
            w_f2i_res = w_sign ? w_sat_neg : w_sat_pos;
        end else begin
            w_wide = {32'd0, 1'b1, w_man} << (w_exp - 8'd127);
            w_int  = w_wide[55:23];
            if (i_signed) begin
                if (!w_sign) begin
                    if (w_int > 33'h0_7FFF_FFFF) begin
                        w_f2i_nv  = 1'b1;
                        w_f2i_res = 32'h7FFF_FFFF;
                    end else begin
                        w_f2i_res = w_int[31:0];
                    end
                end else begin
                    if (w_int > 33'h0_8000_0000) begin
                        w_f2i_nv  = 1'b1;
                        w_f2i_res = 32'h8000_0000;
                    end else begin
                        w_f2i_res = 32'd0 - w_int[31:0];
                    end
                end
            end else begin
                if (w_sign) begin
                    // exponent >= 127 means magnitude >= 1, so never truncates to 0 here
                    w_f2i_nv  = 1'b1;
                    w_f2i_res = 32'd0;
                end else if (w_int[32]) begin
                    w_f2i_nv  = 1'b1;
                    w_f2i_res = 32'hFFFF_FFFF;
                end else begin
                    w_f2i_res = w_int[31:0];
                end
            end
            w_f2i_nx = (|w_wide[22:0]) & ~w_f2i_nv;
        end
    end

    // Int to float: normalise to bit 31, keep 24 bits, round to nearest even.
    always_comb begin
        w_i2f_sign = i_signed & i_a[31];
        w_mag      = w_i2f_sign ? (32'd0 - i_a) : i_a;
        w_msb      = 5'd0;
        for (int i = 0; i < 32; i++) begin
            w_msb = w_mag[i] ? 5'(i) : w_msb;
        end
        w_norm    = w_mag << (5'd31 - w_msb);
        w_sig     = w_norm[31:8];
        w_guard   = w_norm[7];
        w_sticky  = |w_norm[6:0];
        w_rup     = w_guard & (w_sticky | w_sig[0]);
        w_sig_rnd = {1'b0, w_sig} + {24'd0, w_rup};
        w_fexp    = 8'd127 + {3'd0, w_msb} + {7'd0, w_sig_rnd[24]};
        if (w_mag == 32'd0) begin
            w_i2f_res = 32'd0;
            w_i2f_nx  = 1'b0;
        end else begin
            w_i2f_res = {w_i2f_sign, w_fexp,
                         w_sig_rnd[24] ? w_sig_rnd[23:1] : w_sig_rnd[22:0]};
            w_i2f_nx  = w_guard | w_sticky;
        end
    end

    assign o_result = i_dir ? w_i2f_res : w_f2i_res;
    assign o_nv     = i_dir ? 1'b0      : w_f2i_nv;
    assign o_nx     = i_dir ? w_i2f_nx  : w_f2i_nx;

endmodule

// File: rtl/alu_seq.sv
// Handshaked scalar/FP-single ALU with registered results, a 1-deep output
// stage and an iterative shift-add multiplier.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CMD_W = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [CMD_W-1:0] alu_cmd_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  rd_data_o,
    output logic             zero_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [4:0]       fflags_o,
    output logic             illegal_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    state_e           r_state;
    state_e           w_state_next;
    logic             r_out_valid;
    logic [XLEN-1:0]  r_rd_data;
    logic [TAG_W-1:0] r_tag;
    logic [4:0]       r_fflags;
    logic             r_illegal;
    logic [XLEN-1:0]  r_mcand;
    logic [XLEN-1:0]  r_mplier;
    logic [XLEN-1:0]  r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [XLEN-1:0]  w_acc_next;
    logic [XLEN-1:0]  w_res;
    logic [4:0]       w_flags;
    logic [4:0]       w_cvt_flags;
    logic             w_illegal;
    logic [9:0]       w_class;
    logic             w_cvt_dir;
    logic             w_cvt_signed;
    logic [31:0]      w_cvt_res;
    logic             w_cvt_nv;
    logic             w_cvt_nx;

    assign in_ready_o   = (r_state != ST_MUL_RUN) && (!r_out_valid || out_ready_i);
    assign w_accept     = in_valid_i && in_ready_o;
    assign w_is_mul     = (alu_cmd_i == CMD_W'(CMD_MUL));
    assign w_mul_done   = (r_state == ST_MUL_RUN) && (r_cnt == CNT_W'(XLEN - 1));
    assign w_acc_next   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_cvt_dir    = (alu_cmd_i == CMD_W'(CMD_FCVT_S_W)) || (alu_cmd_i == CMD_W'(CMD_FCVT_S_WU));
    assign w_cvt_signed = (alu_cmd_i == CMD_W'(CMD_FCVT_W_S)) || (alu_cmd_i == CMD_W'(CMD_FCVT_S_W));

    fp_cvt_unit u_fp_cvt (
        .i_a      (rs1_data_i[31:0]),
        .i_signed (w_cvt_signed),
        .i_dir    (w_cvt_dir),
        .o_result (w_cvt_res),
        .o_nv     (w_cvt_nv),
        .o_nx     (w_cvt_nx)
    );

    // Converter exception flags in {NV,DZ,OF,UF,NX} order.
    always_comb begin
        w_cvt_flags          = 5'd0;
        w_cvt_flags[FLAG_NV] = w_cvt_nv;
        w_cvt_flags[FLAG_DZ] = 1'b0;
        w_cvt_flags[FLAG_OF] = 1'b0;
        w_cvt_flags[FLAG_UF] = 1'b0;
        w_cvt_flags[FLAG_NX] = w_cvt_nx;
    end

    // FCLASS of rs1[31:0]; exactly one bit is set.
    always_comb begin
        w_class = 10'd0;
        if (rs1_data_i[30:23] == 8'hFF) begin
            if (rs1_data_i[22:0] != 23'd0) begin
                if (rs1_data_i[22]) begin
                    w_class[FCLASS_QNAN] = 1'b1;
                end else begin
                    w_class[FCLASS_SNAN] = 1'b1;
                end
            end else if (rs1_data_i[31]) begin
                w_class[FCLASS_NEG_INF] = 1'b1;
            end else begin
                w_class[FCLASS_POS_INF] = 1'b1;
            end
        end else if (rs1_data_i[30:23] == 8'h00) begin
            if (rs1_data_i[22:0] == 23'd0) begin
                w_class[rs1_data_i[31] ? FCLASS_NEG_ZERO : FCLASS_POS_ZERO] = 1'b1;
            end else begin
                w_class[rs1_data_i[31] ? FCLASS_NEG_SUB : FCLASS_POS_SUB] = 1'b1;
            end
        end else begin
            w_class[rs1_data_i[31] ? FCLASS_NEG_NORM : FCLASS_POS_NORM] = 1'b1;
        end
    end

    // Single-cycle result decode; MUL results come from the iterative path.
    always_comb begin
        w_res     = '0;
        w_flags   = 5'd0;
        w_illegal = 1'b0;
        case (alu_cmd_i)
            CMD_W'(CMD_ADD):                   w_res = rs1_data_i + rs2_data_i;
            CMD_W'(CMD_SUB):                   w_res = rs1_data_i - rs2_data_i;
            CMD_W'(CMD_MOV0), CMD_W'(CMD_MOV1): w_res = rs1_data_i;
            CMD_W'(CMD_MUL):                   w_res = '0;
            CMD_W'(CMD_FSGNJ):  w_res = XLEN'({rs2_data_i[31], rs1_data_i[30:0]});
            CMD_W'(CMD_FSGNJN): w_res = XLEN'({~rs2_data_i[31], rs1_data_i[30:0]});
            CMD_W'(CMD_FSGNJX): w_res = XLEN'({rs1_data_i[31] ^ rs2_data_i[31], rs1_data_i[30:0]});
            CMD_W'(CMD_FCLASS): w_res = XLEN'(w_class);
            CMD_W'(CMD_FCVT_W_S), CMD_W'(CMD_FCVT_WU_S): begin
                w_res   = XLEN'($signed(w_cvt_res));
                w_flags = w_cvt_flags;
            end
            CMD_W'(CMD_FCVT_S_W), CMD_W'(CMD_FCVT_S_WU): begin
                w_res   = XLEN'(w_cvt_res);
                w_flags = w_cvt_flags;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Control FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Control FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_OUT_HOLD: begin
                if (w_accept) begin
                    w_state_next = w_is_mul ? ST_MUL_RUN : ST_OUT_HOLD;
                end else if ((r_state == ST_OUT_HOLD) && out_ready_i) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = r_state;
                end
            end
            ST_MUL_RUN: begin
                w_state_next = w_mul_done ? ST_OUT_HOLD : ST_MUL_RUN;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output stage and multiplier datapath; outputs only change when free or consumed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
            r_rd_data   <= '0;
            r_tag       <= '0;
            r_fflags    <= 5'd0;
            r_illegal   <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else if (w_accept && w_is_mul) begin
            r_out_valid <= 1'b0;
            r_tag       <= tag_i;
            r_mcand     <= rs1_data_i;
            r_mplier    <= rs2_data_i;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_rd_data   <= w_res;
            r_tag       <= tag_i;
            r_fflags    <= w_flags;
            r_illegal   <= w_illegal;
        end else if (r_state == ST_MUL_RUN) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_mul_done) begin
                r_out_valid <= 1'b1;
                r_rd_data   <= w_acc_next;
                r_fflags    <= 5'd0;
                r_illegal   <= 1'b0;
            end
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid_o = r_out_valid;
    assign rd_data_o   = r_rd_data;
    assign zero_o      = (r_rd_data == '0);
    assign tag_o       = r_tag;
    assign fflags_o    = r_fflags;
    assign illegal_o   = r_illegal;
    assign busy_o      = (r_state == ST_MUL_RUN);

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq: handshake, stall, MUL timing,
// reset abort and the FP/conversion command set.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  cmd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rd;
    logic        zero;
    logic [3:0]  tag_out;
    logic [4:0]  fflags;
    logic        illegal;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rd;
        logic [4:0]  fl;
        logic        ill;
    } vec_t;

    alu_seq #(.XLEN(32), .CMD_W(8), .TAG_W(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .alu_cmd_i   (cmd),
        .rs1_data_i  (rs1),
        .rs2_data_i  (rs2),
        .tag_i       (tag_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .rd_data_o   (rd),
        .zero_o      (zero),
        .tag_o       (tag_out),
        .fflags_o    (fflags),
        .illegal_o   (illegal),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [7:0] c, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        in_valid = 1'b1;
        cmd      = c;
        rs1      = a;
        rs2      = b;
        tag_in   = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cmd = 8'd0; rs1 = 32'd0; rs2 = 32'd0; tag_in = 4'd0;
        #23;
        n_total++; if ({out_valid, busy, illegal} !== 3'b000) $display("FAIL reset_flags: got %b need 000", {out_valid, busy, illegal}); else n_pass++;
        n_total++; if (rd !== 32'd0 || tag_out !== 4'd0 || fflags !== 5'd0) $display("FAIL reset_data: got rd=%h tag=%h ff=%b need 0", rd, tag_out, fflags); else n_pass++;
        n_total++; if (zero !== 1'b1) $display("FAIL reset_zero: got %b need 1", zero); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b need 1", in_ready); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(8'd1, 32'd5, 32'd7, 4'd3);
        tick();
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL add_valid: got %b need 1", out_valid); else n_pass++;
        n_total++; if (rd !== 32'd12) $display("FAIL add_rd: got %h need %h", rd, 32'd12); else n_pass++;
        n_total++; if (tag_out !== 4'd3 || zero !== 1'b0) $display("FAIL add_tag_zero: got tag=%h zero=%b need tag=3 zero=0", tag_out, zero); else n_pass++;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL add_drain: got %b need 0", out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(8'd1, 32'd1, 32'd1, 4'd1);
        tick();
        for (int i = 2; i <= 4; i++) begin
            if (i <= 3) drive(8'd1, 32'(i), 32'(i), 4'(i)); else in_valid = 1'b0;
            n_total++;
            if (out_valid !== 1'b1 || rd !== 32'(2 * (i - 1)) || tag_out !== 4'(i - 1))
                $display("FAIL b2b_%0d: got v=%b rd=%h tag=%h need v=1 rd=%h tag=%h", i - 1, out_valid, rd, tag_out, 32'(2 * (i - 1)), 4'(i - 1));
            else n_pass++;
            tick();
        end
        n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b need 0", out_valid); else n_pass++;
    endtask

    task automatic test_sub_stall();
        out_ready = 1'b0;
        drive(8'd4, 32'd7, 32'd7, 4'd5);
        tick();
        drive(8'd1, 32'd1, 32'd1, 4'd6);
        for (int c = 0; c < 4; c++) begin
            #1;
            n_total++;
            if (out_valid !== 1'b1 || rd !== 32'd0 || zero !== 1'b1 || tag_out !== 4'd5 || in_ready !== 1'b0)
                $display("FAIL sub_stall_c%0d: got v=%b rd=%h z=%b tag=%h rdy=%b need v=1 rd=0 z=1 tag=5 rdy=0", c, out_valid, rd, zero, tag_out, in_ready);
            else n_pass++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b need 1", in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1 || rd !== 32'd2 || tag_out !== 4'd6) $display("FAIL stall_next: got v=%b rd=%h tag=%h need v=1 rd=2 tag=6", out_valid, rd, tag_out); else n_pass++;
        tick();
    endtask

    task automatic test_mul();
        int cyc;
        int busy_cnt;
        out_ready = 1'b1;
        drive(8'd90, 32'd3, 32'hFFFF_FFFF, 4'd9);
        tick();
        in_valid = 1'b0;
        n_total++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL mul_start: got busy=%b rdy=%b need busy=1 rdy=0", busy, in_ready); else n_pass++;
        cyc = 1;
        busy_cnt = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            cyc++;
        end
        n_total++; if (cyc !== 33) $display("FAIL mul_latency: got %0d need 33", cyc); else n_pass++;
        n_total++; if (busy_cnt !== 32) $display("FAIL mul_busy_cycles: got %0d need 32", busy_cnt); else n_pass++;
        n_total++; if (rd !== 32'hFFFF_FFFD || tag_out !== 4'd9) $display("FAIL mul_result: got rd=%h tag=%h need rd=fffffffd tag=9", rd, tag_out); else n_pass++;
        n_total++; if (busy !== 1'b0 || fflags !== 5'd0 || illegal !== 1'b0) $display("FAIL mul_status: got busy=%b ff=%b ill=%b need 0", busy, fflags, illegal); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        out_ready = 1'b1;
        drive(8'd90, 32'd5, 32'd5, 4'd2);
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        n_total++; if (busy !== 1'b1) $display("FAIL mid_mul_busy: got %b need 1", busy); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || rd !== 32'd0 || tag_out !== 4'd0 || zero !== 1'b1)
            $display("FAIL mid_mul_reset: got v=%b busy=%b rd=%h tag=%h z=%b need 0 0 0 0 1", out_valid, busy, rd, tag_out, zero);
        else n_pass++;
        #2 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_total++; if (seen !== 0) $display("FAIL mid_mul_no_result: got %0d active cycles need 0", seen); else n_pass++;
    endtask

    task automatic test_fp();
        vec_t v[$];
        v.push_back('{8'd79,  32'h4049_0FDB, 32'd0,         32'h0000_0003, 5'b00001, 1'b0});
        v.push_back('{8'd79,  32'h7FC0_0000, 32'd0,         32'h7FFF_FFFF, 5'b10000, 1'b0});
        v.push_back('{8'd79,  32'hCF80_0000, 32'd0,         32'h8000_0000, 5'b10000, 1'b0});
        v.push_back('{8'd80,  32'hBF80_0000, 32'd0,         32'h0000_0000, 5'b10000, 1'b0});
        v.push_back('{8'd86,  32'd16777217,  32'd0,         32'h4B80_0000, 5'b00001, 1'b0});
        v.push_back('{8'd87,  32'hFFFF_FFFF, 32'd0,         32'h4F80_0000, 5'b00001, 1'b0});
        v.push_back('{8'd75,  32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0000, 5'b00000, 1'b0});
        v.push_back('{8'd85,  32'h8000_0000, 32'd0,         32'h0000_0008, 5'b00000, 1'b0});
        v.push_back('{8'd200, 32'h1234_5678, 32'h1,         32'h0000_0000, 5'b00000, 1'b1});
        v.push_back('{8'd79,  32'hC049_0FDB, 32'd0,         32'hFFFF_FFFD, 5'b00001, 1'b0});
        v.push_back('{8'd80,  32'hBF00_0000, 32'd0,         32'h0000_0000, 5'b00001, 1'b0});
        v.push_back('{8'd79,  32'h4F00_0000, 32'd0,         32'h7FFF_FFFF, 5'b10000, 1'b0});
        v.push_back('{8'd79,  32'hCF00_0000, 32'd0,         32'h8000_0000, 5'b00000, 1'b0});
        v.push_back('{8'd80,  32'h4F80_0000, 32'd0,         32'hFFFF_FFFF, 5'b10000, 1'b0});
        v.push_back('{8'd86,  32'hFFFF_FFFF, 32'd0,         32'hBF80_0000, 5'b00000, 1'b0});
        v.push_back('{8'd76,  32'hBF80_0000, 32'hBF80_0000, 32'h3F80_0000, 5'b00000, 1'b0});
        v.push_back('{8'd74,  32'h3F80_0000, 32'h8000_0000, 32'hBF80_0000, 5'b00000, 1'b0});
        v.push_back('{8'd85,  32'h7FC0_0000, 32'd0,         32'h0000_0200, 5'b00000, 1'b0});
        v.push_back('{8'd85,  32'h0000_0001, 32'd0,         32'h0000_0020, 5'b00000, 1'b0});
        v.push_back('{8'd85,  32'hFF80_0000, 32'd0,         32'h0000_0001, 5'b00000, 1'b0});
        v.push_back('{8'd2,   32'h0000_1234, 32'h5,         32'h0000_1234, 5'b00000, 1'b0});
        v.push_back('{8'd3,   32'hCAFE_0000, 32'h5,         32'hCAFE_0000, 5'b00000, 1'b0});
        v.push_back('{8'd4,   32'h0000_0000, 32'h1,         32'hFFFF_FFFF, 5'b00000, 1'b0});
        v.push_back('{8'd1,   32'hFFFF_FFFF, 32'h1,         32'h0000_0000, 5'b00000, 1'b0});
        out_ready = 1'b1;
        foreach (v[i]) begin
            drive(v[i].cmd, v[i].a, v[i].b, 4'(i));
            tick();
            in_valid = 1'b0;
            n_total++;
            if (out_valid !== 1'b1 || rd !== v[i].rd || fflags !== v[i].fl || illegal !== v[i].ill ||
                zero !== (v[i].rd == 32'd0) || tag_out !== 4'(i))
                $display("FAIL fp_vec%0d cmd=%0d: got v=%b rd=%h ff=%b ill=%b z=%b tag=%h need v=1 rd=%h ff=%b ill=%b",
                         i, v[i].cmd, out_valid, rd, fflags, illegal, zero, tag_out, v[i].rd, v[i].fl, v[i].ill);
            else n_pass++;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_sub_stall();
        test_mul();
        test_reset_mid_mul();
        test_fp();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
